// File: rtl/counter_sched_pkg.sv
// Shared definitions for the two-requester counter scheduler.
package counter_sched_pkg;

  localparam int WIDTH_DEF = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    RUN  = 2'd2,
    DONE = 2'd3
  } state_t;

endpackage

// File: rtl/counter_sched_core.sv
// Loadable, enabled up-counter owned by the scheduler FSM; wraps modulo 2^WIDTH.
module counter_core #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic             en,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  always_ff @(posedge clk) begin
    if (!reset) begin
      q <= '0;
    end else if (load) begin
      q <= d;
    end else if (en) begin
      q <= q + WIDTH'(1);
    end
  end

endmodule

// File: rtl/counter_sched.sv
// Round-robin arbiter plus sequencing FSM that lends one shared counter to
// one of two requesters at a time and pulses done when its run hits the limit.
//
// state | meaning
// IDLE  | no owner; arbitrate pending requests
// LOAD  | owner granted; counter loads the latched start value
// RUN   | counting toward the latched limit while e is high
// DONE  | limit reached; one-cycle done pulse to the owner
module counter_sched
  import counter_sched_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             e,
  input  logic             req0,
  input  logic             req1,
  input  logic [WIDTH-1:0] load0,
  input  logic [WIDTH-1:0] load1,
  input  logic [WIDTH-1:0] limit0,
  input  logic [WIDTH-1:0] limit1,
  output logic             gnt0,
  output logic             gnt1,
  output logic             done0,
  output logic             done1,
  output logic             busy,
  output logic [WIDTH-1:0] q
);

  state_t           state;
  logic             sel;
  logic             last;
  logic [WIDTH-1:0] lat_load;
  logic [WIDTH-1:0] lat_limit;

  logic             owner_req;
  logic             winner;
  logic [WIDTH-1:0] q_next;
  logic             core_load;
  logic             core_en;

  assign owner_req = sel ? req1 : req0;
  // On contention the requester not served last wins.
  assign winner    = (req0 && req1) ? ~last : req1;
  assign q_next    = q + WIDTH'(1);

  // The counter only moves while the owner still holds its request, so an
  // abort in LOAD or RUN leaves q untouched.
  assign core_load = (state == LOAD) && owner_req;
  assign core_en   = (state == RUN) && e && owner_req;

  always_ff @(posedge clk) begin
    if (!reset) begin
      state     <= IDLE;
      sel       <= 1'b0;
      last      <= 1'b1;
      lat_load  <= '0;
      lat_limit <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (req0 || req1) begin
            sel       <= winner;
            lat_load  <= winner ? load1 : load0;
            lat_limit <= winner ? limit1 : limit0;
            state     <= LOAD;
          end
        end
        LOAD: begin
          if (!owner_req) begin
            last  <= sel;
            state <= IDLE;
          end else begin
            state <= (lat_load == lat_limit) ? DONE : RUN;
          end
        end
        RUN: begin
          if (!owner_req) begin
            last  <= sel;
            state <= IDLE;
          end else if (e && (q_next == lat_limit)) begin
            state <= DONE;
          end
        end
        DONE: begin
          last  <= sel;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  counter_core #(.WIDTH(WIDTH)) u_core (
    .clk   (clk),
    .reset (reset),
    .load  (core_load),
    .en    (core_en),
    .d     (lat_load),
    .q     (q)
  );

  assign busy  = (state != IDLE);
  assign gnt0  = busy && !sel;
  assign gnt1  = busy && sel;
  assign done0 = (state == DONE) && !sel;
  assign done1 = (state == DONE) && sel;

endmodule

// File: tb/tb_counter_sched.sv
// Directed and randomized checks of counter_sched against a transaction-level
// model that tracks owner, remaining enabled cycles and counter value.
module tb_counter_sched;

  localparam int W = 4;
  localparam int M = 1 << W;

  logic         clk = 1'b0;
  logic         reset, e, req0, req1;
  logic [W-1:0] load0, load1, limit0, limit1;
  logic         gnt0, gnt1, done0, done1, busy;
  logic [W-1:0] q;

  int vectors    = 0;
  int miscompares = 0;

  // reference model: owner -1 means nobody holds the counter
  int m_owner = -1;
  int m_phase = 0;   // 0 just granted, 1 counting, 2 finished
  int m_last  = 1;
  int m_q     = 0;
  int m_rem   = 0;
  int m_ld    = 0;
  int m_lim   = 0;

  counter_sched #(.WIDTH(W)) dut (
    .clk    (clk),
    .reset  (reset),
    .e      (e),
    .req0   (req0),
    .req1   (req1),
    .load0  (load0),
    .load1  (load1),
    .limit0 (limit0),
    .limit1 (limit1),
    .gnt0   (gnt0),
    .gnt1   (gnt1),
    .done0  (done0),
    .done1  (done1),
    .busy   (busy),
    .q      (q)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      miscompares++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic model_edge();
    bit r [2];
    r[0] = req0;
    r[1] = req1;
    if (!reset) begin
      m_owner = -1;
      m_q     = 0;
      m_last  = 1;
    end else if (m_owner < 0) begin
      if (r[0] || r[1]) begin
        m_owner = (r[0] && r[1]) ? 1 - m_last : (r[1] ? 1 : 0);
        m_ld    = m_owner == 1 ? int'(load1)  : int'(load0);
        m_lim   = m_owner == 1 ? int'(limit1) : int'(limit0);
        m_phase = 0;
      end
    end else if (m_phase == 2) begin
      m_last  = m_owner;
      m_owner = -1;
    end else if (!r[m_owner]) begin
      m_last  = m_owner;
      m_owner = -1;
    end else if (m_phase == 0) begin
      m_q     = m_ld;
      m_rem   = (m_lim - m_ld + M) % M;
      m_phase = (m_rem == 0) ? 2 : 1;
    end else if (e) begin
      m_q = (m_q + 1) % M;
      m_rem--;
      if (m_rem == 0) m_phase = 2;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
    check("gnt0",  gnt0,  m_owner == 0);
    check("gnt1",  gnt1,  m_owner == 1);
    check("done0", done0, (m_owner == 0) && (m_phase == 2));
    check("done1", done1, (m_owner == 1) && (m_phase == 2));
    check("busy",  busy,  m_owner >= 0);
    check("q",     q,     m_q);
    check("exclusive_gnt", gnt0 && gnt1, 0);
  endtask

  task automatic do_reset();
    reset = 1'b0;
    req0  = 1'b0;
    req1  = 1'b0;
    tick();
    tick();
    reset = 1'b1;
  endtask

  int gcount;
  int d1_seen;
  int order [$];
  logic prev_busy;

  initial begin
    reset = 1'b0; e = 1'b0; req0 = 1'b0; req1 = 1'b0;
    load0 = '0; load1 = '0; limit0 = '0; limit1 = '0;
    do_reset();

    // single run 3 -> 7
    load0 = 4'd3; limit0 = 4'd7; e = 1'b1; req0 = 1'b1;
    gcount = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (gnt0) gcount++;
      if (done0) req0 = 1'b0;
    end
    check("single_gnt0_cycles", gcount, 6);

    // reset asserted mid-RUN
    req0 = 1'b1;
    tick(); tick(); tick();
    reset = 1'b0;
    tick(); tick();
    check("reset_busy", busy, 0);
    check("reset_q", q, 0);
    reset = 1'b1; req0 = 1'b0;
    tick();

    // contention: both held, alternating service starting with requester 0
    do_reset();
    load0 = 4'd1; limit0 = 4'd3; load1 = 4'd2; limit1 = 4'd4;
    req0 = 1'b1; req1 = 1'b1;
    prev_busy = 1'b0;
    order.delete();
    for (int i = 0; i < 20; i++) begin
      tick();
      if (busy && !prev_busy) order.push_back(int'(gnt1));
      prev_busy = busy;
    end
    check("contention_grants", order.size() >= 3, 1);
    if (order.size() >= 3) begin
      check("contention_first",  order[0], 0);
      check("contention_second", order[1], 1);
      check("contention_third",  order[2], 0);
    end
    req0 = 1'b0; req1 = 1'b0;
    tick(); tick(); tick(); tick(); tick(); tick();

    // wrap 14 -> 1
    do_reset();
    load1 = 4'd14; limit1 = 4'd1; req1 = 1'b1;
    gcount = 0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (gnt1) gcount++;
      if (done1) req1 = 1'b0;
    end
    check("wrap_gnt1_cycles", gcount, 5);

    // zero-length run
    load0 = 4'd5; limit0 = 4'd5; req0 = 1'b1;
    gcount = 0;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (gnt0) gcount++;
      if (done0) begin
        check("zero_len_q", q, 5);
        req0 = 1'b0;
      end
    end
    check("zero_len_gnt0_cycles", gcount, 2);

    // pause at q=5
    do_reset();
    load0 = 4'd3; limit0 = 4'd7; req0 = 1'b1; e = 1'b1;
    gcount = 0;
    for (int i = 0; i < 13; i++) begin
      if (i == 4) e = 1'b0;
      if (i == 7) e = 1'b1;
      tick();
      if (gnt0) gcount++;
      if (done0) req0 = 1'b0;
    end
    check("pause_gnt0_cycles", gcount, 9);

    // abort requester 1 at q=2
    do_reset();
    load1 = 4'd0; limit1 = 4'd6; req1 = 1'b1;
    tick(); tick(); tick(); tick();
    check("abort_q_before", q, 2);
    req1 = 1'b0;
    d1_seen = 0;
    tick();
    if (done1) d1_seen++;
    check("abort_q_hold", q, 2);
    check("abort_idle", busy, 0);
    tick();
    if (done1) d1_seen++;
    check("abort_no_done1", d1_seen, 0);
    req0 = 1'b1; req1 = 1'b1; load0 = 4'd2; limit0 = 4'd4;
    tick();
    check("abort_next_winner0", gnt0, 1);
    req0 = 1'b0; req1 = 1'b0;
    tick(); tick();

    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      reset = ($urandom_range(0, 99) != 0);
      e     = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 7) == 0) req0 = ~req0;
      if ($urandom_range(0, 7) == 0) req1 = ~req1;
      if (done0 && $urandom_range(0, 1) == 0) req0 = 1'b0;
      if (done1 && $urandom_range(0, 1) == 0) req1 = 1'b0;
      load0  = W'($urandom_range(0, M - 1));
      load1  = W'($urandom_range(0, M - 1));
      limit0 = W'($urandom_range(0, M - 1));
      limit1 = W'($urandom_range(0, M - 1));
      tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/counter_sched.md
COUNTER_SCHED -- requirements
Module: counter_sched

Interface
REQ-001 Parameter WIDTH, default 4, width of the counter, load and limit values.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 reset  input  1  synchronous, active-low reset.
REQ-004 e  input  1  global run enable; low pauses counting.
REQ-005 req0, req1  input  1 each  level request from requester 0 or 1; held until done or abort.
REQ-006 load0, load1  input  WIDTH each  start value for each requester.
REQ-007 limit0, limit1  input  WIDTH each  terminal value for each requester.
REQ-008 gnt0, gnt1  output  1 each  requester owns the counter; never both high.
REQ-009 done0, done1  output  1 each  one-cycle pulse when the owner's run reaches its limit.
REQ-010 busy  output  1  high in every state except IDLE.
REQ-011 q  output  WIDTH  current counter value.

Function
REQ-012 The FSM SHALL have four states: IDLE, LOAD, RUN, DONE.
REQ-013 IDLE: any req high -> LOAD on the next edge; latch the winner index sel plus its load and limit values.
- One req high: that requester wins.
- Both high: the requester not served last wins.
REQ-014 LOAD: q <= latched load; next state is DONE if load == limit, else RUN.
REQ-015 RUN with e=1: q <= q+1 modulo 2^WIDTH (wraps past all-ones to 0); DONE when q+1 == limit.
REQ-016 RUN with e=0: q and state SHALL hold.
REQ-017 RUN duration SHALL be (limit - load) mod 2^WIDTH enabled cycles.
REQ-018 DONE: q holds; next edge -> IDLE; last-served <= sel.
REQ-019 Owner drops its req in LOAD or RUN (abort): next edge -> IDLE, no done pulse, q holds, last-served <= sel.
REQ-020 Latched load and limit SHALL ignore input changes after the IDLE->LOAD edge.
REQ-021 Output decodes from registered state only:
- gntX = (state != IDLE) and (sel == X).
- doneX = (state == DONE) and (sel == X).
- busy = (state != IDLE).
REQ-022 Latency: req seen in IDLE -> gnt high the next cycle; q = load one cycle later.
REQ-023 req still high in IDLE after done SHALL count as a new request, subject to round-robin.
REQ-024 A non-owner req raised while busy SHALL wait and be arbitrated in the next IDLE cycle.

Reset
REQ-025 reset=0 at an edge SHALL force state=IDLE, q=0, sel=0, last-served=1, in any state including mid-RUN.
REQ-026 Consequences of REQ-025: gnt0=gnt1=0, done0=done1=0, busy=0 from the following cycle; requester 0 has first priority.
REQ-027 Reset SHALL override every other input in the same cycle.

Structure
REQ-028 Shared package counter_sched_pkg SHALL hold the state enumeration (IDLE, LOAD, RUN, DONE) and the default WIDTH constant.
REQ-029 The loadable enabled counter SHALL be a sub-module counter_core (clk, reset, load, en, d, q), driven by the FSM.
REQ-030 The arbiter and FSM SHALL remain in counter_sched.

Verification (WIDTH=4)
REQ-031 Reset: reset=0 for 2 cycles mid-RUN -> q=0, gnt=00, done=00, busy=0 the next cycle.
REQ-032 Single run: req0, load0=3, limit0=7, e=1 -> gnt0 one cycle later; q=3,4,5,6 in RUN, 7 in DONE; done0 one pulse; gnt0 high 6 cycles.
REQ-033 Contention: req0 and req1 together after reset, both held -> requester 0 first, then requester 1, then requester 0; never both granted.
REQ-034 Wrap and zero-length:
- load1=14, limit1=1 -> q=14,15,0,1, three RUN cycles.
- load0=limit0=5 -> LOAD then DONE directly, done0 with q=5.
REQ-035 Pause: e=0 for 3 cycles at q=5 (load 3, limit 7) -> q holds 5, gnt0 held, done0 3 cycles later than REQ-032.
REQ-036 Abort: req1 dropped while q=2 in RUN -> IDLE next cycle, done1 never pulses, q stays 2, next contention won by requester 0.
